// File: rtl/gfx_pixel_rmw_if.sv
// rtl/gfx_pixel_rmw_if.sv - pixel request/response and memory bus bundle for gfx_pixel_rmw
// Ports (slave = pixel unit view):
//   req_*  : pixel request in (valid/ready, we, word address, bit offset, bpp, colour)
//   rsp_*  : read response out (one-cycle valid pulse, extracted colour)
//   mem_*  : word bus out (cyc/we/adr/sel/dat), read data and ack in
interface gfx_pixel_rmw_if #(
  parameter int MDW = 256,
  parameter int AW  = 32
);
  localparam int MBW = $clog2(MDW);

  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_we_i;
  logic [AW-1:0]    req_adr_i;
  logic [MBW-1:0]   req_mb_i;
  logic [5:0]       req_bpp_i;
  logic [31:0]      req_color_i;
  logic             rsp_valid_o;
  logic [31:0]      rsp_color_o;
  logic             mem_cyc_o;
  logic             mem_we_o;
  logic [AW-1:0]    mem_adr_o;
  logic [MDW/8-1:0] mem_sel_o;
  logic [MDW-1:0]   mem_dat_o;
  logic [MDW-1:0]   mem_dat_i;
  logic             mem_ack_i;

  modport slave (
    input  req_valid_i, req_we_i, req_adr_i, req_mb_i, req_bpp_i, req_color_i,
    output req_ready_o, rsp_valid_o, rsp_color_o,
    output mem_cyc_o, mem_we_o, mem_adr_o, mem_sel_o, mem_dat_o,
    input  mem_dat_i, mem_ack_i
  );

  modport master (
    output req_valid_i, req_we_i, req_adr_i, req_mb_i, req_bpp_i, req_color_i,
    input  req_ready_o, rsp_valid_o, rsp_color_o,
    input  mem_cyc_o, mem_we_o, mem_adr_o, mem_sel_o, mem_dat_o,
    output mem_dat_i, mem_ack_i
  );
endinterface

// File: rtl/gfx_pixel_rmw.sv
// rtl/gfx_pixel_rmw.sv - pixel read / write / read-modify-write unit on an MDW-bit word bus
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : gfx_pixel_rmw_if.slave (pixel request, read response, memory bus)
module gfx_pixel_rmw #(
  parameter int MDW = 256,
  parameter int AW  = 32
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  gfx_pixel_rmw_if.slave bus
);
  localparam int MBW  = $clog2(MDW);
  localparam int NSEL = MDW / 8;

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_e;

  state_e           state_q, state_d;
  logic [MBW-1:0]   mb_q, mb_d;
  logic [31:0]      mask_q, mask_d;
  logic [31:0]      color_q, color_d;
  logic             we_q, we_d;
  logic [31:0]      rsp_color_q, rsp_color_d;
  logic             mem_cyc_q, mem_cyc_d;
  logic             mem_we_q, mem_we_d;
  logic [AW-1:0]    mem_adr_q, mem_adr_d;
  logic [NSEL-1:0]  mem_sel_q, mem_sel_d;
  logic [MDW-1:0]   mem_dat_q, mem_dat_d;

  // Request decode: effective bpp, pixel mask and aligned-write detection.
  logic [5:0]       req_eff_bpp;
  logic [31:0]      req_mask;
  logic             req_aligned;

  always_comb begin
    req_eff_bpp = bus.req_bpp_i;
    if (bus.req_bpp_i == 6'd0 || bus.req_bpp_i > 6'd32) begin
      req_eff_bpp = 6'd32;
    end
    req_mask    = (req_eff_bpp == 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << req_eff_bpp) - 32'd1);
    req_aligned = (bus.req_mb_i[2:0] == 3'd0) && (bus.req_bpp_i[2:0] == 3'd0);
  end

  // Packer shared by both write paths. In IDLE it works on the incoming request with a
  // zero background (aligned path); otherwise on the registered pixel merged into the word
  // just read. Bits shifted past MDW fall off the top, which clips both data and selects.
  logic [MBW-1:0]   pk_mb;
  logic [31:0]      pk_mask;
  logic [31:0]      pk_color;
  logic [MDW-1:0]   pk_base;
  logic [MDW-1:0]   pk_mask_sh;
  logic [MDW-1:0]   pk_dat;
  logic [NSEL-1:0]  pk_sel;

  always_comb begin
    if (state_q == IDLE) begin
      pk_mb    = bus.req_mb_i;
      pk_mask  = req_mask;
      pk_color = bus.req_color_i;
      pk_base  = '0;
    end else begin
      pk_mb    = mb_q;
      pk_mask  = mask_q;
      pk_color = color_q;
      pk_base  = bus.mem_dat_i;
    end
    pk_mask_sh = MDW'(pk_mask) << pk_mb;
    pk_dat     = (MDW'(pk_color & pk_mask) << pk_mb) | (pk_base & ~pk_mask_sh);
    pk_sel     = '0;
    for (int i = 0; i < NSEL; i++) begin
      pk_sel[i] = |pk_mask_sh[8*i +: 8];
    end
  end

  // Read extraction: bits above MDW shift in as zero, so overflowing pixels read as zero.
  logic [MDW-1:0] rd_shift;
  assign rd_shift = bus.mem_dat_i >> mb_q;

  always_comb begin
    state_d     = state_q;
    mb_d        = mb_q;
    mask_d      = mask_q;
    color_d     = color_q;
    we_d        = we_q;
    rsp_color_d = rsp_color_q;
    mem_cyc_d   = mem_cyc_q;
    mem_we_d    = mem_we_q;
    mem_adr_d   = mem_adr_q;
    mem_sel_d   = mem_sel_q;
    mem_dat_d   = mem_dat_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          mb_d      = bus.req_mb_i;
          mask_d    = req_mask;
          color_d   = bus.req_color_i;
          we_d      = bus.req_we_i;
          mem_cyc_d = 1'b1;
          mem_adr_d = bus.req_adr_i;
          if (bus.req_we_i && req_aligned) begin
            state_d   = WR;
            mem_we_d  = 1'b1;
            mem_sel_d = pk_sel;
            mem_dat_d = pk_dat;
          end else begin
            state_d   = RD;
            mem_we_d  = 1'b0;
            mem_sel_d = '1;
            mem_dat_d = '0;
          end
        end
      end
      RD: begin
        if (bus.mem_ack_i) begin
          if (we_q) begin
            // Bus cycle continues straight into the write half of the RMW.
            state_d   = WR;
            mem_we_d  = 1'b1;
            mem_sel_d = pk_sel;
            mem_dat_d = pk_dat;
          end else begin
            state_d     = RSP;
            mem_cyc_d   = 1'b0;
            rsp_color_d = rd_shift[31:0] & mask_q;
          end
        end
      end
      WR: begin
        if (bus.mem_ack_i) begin
          state_d   = IDLE;
          mem_cyc_d = 1'b0;
        end
      end
      RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_cyc_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      mb_q        <= '0;
      mask_q      <= '0;
      color_q     <= '0;
      we_q        <= 1'b0;
      rsp_color_q <= '0;
      mem_cyc_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_adr_q   <= '0;
      mem_sel_q   <= '0;
      mem_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      mb_q        <= mb_d;
      mask_q      <= mask_d;
      color_q     <= color_d;
      we_q        <= we_d;
      rsp_color_q <= rsp_color_d;
      mem_cyc_q   <= mem_cyc_d;
      mem_we_q    <= mem_we_d;
      mem_adr_q   <= mem_adr_d;
      mem_sel_q   <= mem_sel_d;
      mem_dat_q   <= mem_dat_d;
    end
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = (state_q == RSP);
  assign bus.rsp_color_o = rsp_color_q;
  assign bus.mem_cyc_o   = mem_cyc_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_adr_o   = mem_adr_q;
  assign bus.mem_sel_o   = mem_sel_q;
  assign bus.mem_dat_o   = mem_dat_q;
endmodule

// File: tb/tb_gfx_pixel_rmw.sv
// tb/tb_gfx_pixel_rmw.sv - self-checking bench for gfx_pixel_rmw with a bit-level reference model
module tb_gfx_pixel_rmw;
  localparam int MDW = 256;
  localparam int AW  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gfx_pixel_rmw_if #(.MDW(MDW), .AW(AW)) bus ();
  gfx_pixel_rmw #(.MDW(MDW), .AW(AW)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [255:0] bus_mem [logic [31:0]];
  logic [255:0] ref_mem [logic [31:0]];

  int          n_rd, n_wr, n_rsp, lat;
  bit          stable_ok;
  logic [31:0] rsp_col, last_wsel, last_rsel, last_wadr, last_radr;
  logic [255:0] last_wdat;
  logic [31:0] hold_color;

  function automatic int eff_of(input int bpp);
    return (bpp == 0 || bpp > 32) ? 32 : bpp;
  endfunction

  function automatic logic [255:0] model_write(input logic [255:0] old, input int mb,
                                               input int bpp, input logic [31:0] col);
    logic [255:0] r = old;
    for (int k = 0; k < eff_of(bpp); k++)
      if (mb + k < 256) r[mb + k] = col[k];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [255:0] w, input int mb, input int bpp);
    logic [31:0] r = '0;
    for (int k = 0; k < eff_of(bpp); k++)
      if (mb + k < 256) r[k] = w[mb + k];
    return r;
  endfunction

  function automatic logic [31:0] model_sel(input int mb, input int bpp);
    logic [31:0] s = '0;
    int hi = (mb + eff_of(bpp) - 1) / 8;
    for (int b = 0; b < 32; b++)
      if (b >= mb / 8 && b <= hi) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [255:0] v);
    bus_mem[a] = v;
    ref_mem[a] = v;
  endtask

  // Drives one pixel request and plays the memory side with `dly` wait cycles per access.
  // With `poke`, a different request is held valid on the port while the unit is busy.
  task automatic do_op(input bit we, input logic [31:0] adr, input int mb, input int bpp,
                       input logic [31:0] col, input int dly, input bit poke);
    bit in_acc, acking, done;
    int wcnt;
    logic s_we; logic [31:0] s_adr, s_sel; logic [255:0] s_dat, w;
    n_rd = 0; n_wr = 0; n_rsp = 0; lat = 0; stable_ok = 1; rsp_col = '0;
    in_acc = 0; acking = 0; done = 0; wcnt = 0;
    s_we = 0; s_adr = '0; s_sel = '0; s_dat = '0;
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_adr_i = adr;
    bus.req_mb_i = mb[7:0]; bus.req_bpp_i = bpp[5:0]; bus.req_color_i = col;
    @(negedge clk);
    if (poke) begin
      bus.req_we_i = ~we; bus.req_adr_i = adr + 32'd1; bus.req_color_i = ~col;
    end else begin
      bus.req_valid_i = 1'b0;
    end
    for (int c = 0; c < 80 && !done; c++) begin
      lat++;
      if (acking) begin bus.mem_ack_i = 1'b0; acking = 0; in_acc = 0; end
      if (bus.req_ready_o) begin
        done = 1;
      end else begin
        if (bus.rsp_valid_o) begin n_rsp++; rsp_col = bus.rsp_color_o; end
        if (bus.mem_cyc_o) begin
          if (!in_acc) begin
            in_acc = 1; wcnt = 0;
            s_we = bus.mem_we_o; s_adr = bus.mem_adr_o; s_sel = bus.mem_sel_o; s_dat = bus.mem_dat_o;
          end else if ({s_we, s_adr, s_sel, s_dat} !== {bus.mem_we_o, bus.mem_adr_o,
                                                        bus.mem_sel_o, bus.mem_dat_o}) begin
            stable_ok = 0;
          end
          if (wcnt == dly) begin
            bus.mem_ack_i = 1'b1; acking = 1; bus.req_valid_i = 1'b0;
            if (!s_we) begin
              n_rd++; last_rsel = s_sel; last_radr = s_adr;
              bus.mem_dat_i = bus_mem.exists(s_adr) ? bus_mem[s_adr] : '0;
            end else begin
              n_wr++; last_wsel = s_sel; last_wadr = s_adr; last_wdat = s_dat;
              w = bus_mem.exists(s_adr) ? bus_mem[s_adr] : '0;
              for (int b = 0; b < 32; b++)
                if (s_sel[b]) w[8*b +: 8] = s_dat[8*b +: 8];
              bus_mem[s_adr] = w;
            end
          end else begin
            wcnt++;
          end
        end
      end
      if (!done) @(negedge clk);
    end
    bus.req_valid_i = 1'b0;
    bus.mem_ack_i = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL op_timeout: req_ready_o never returned (got 0, expected 1)");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.req_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %0b expected 1", bus.req_ready_o);
    end
    checks++;
    if ({bus.mem_cyc_o, bus.mem_we_o, bus.rsp_valid_o} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000",
                         {bus.mem_cyc_o, bus.mem_we_o, bus.rsp_valid_o});
    end
    checks++;
    if ({bus.mem_adr_o, bus.mem_sel_o, bus.rsp_color_o} !== '0 || bus.mem_dat_o !== '0) begin
      errors++; $display("FAIL reset_data: adr %0h sel %0h col %0h expected all 0",
                         bus.mem_adr_o, bus.mem_sel_o, bus.rsp_color_o);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    // Stray ack while idle must be ignored.
    @(negedge clk); bus.mem_ack_i = 1'b1;
    @(negedge clk); bus.mem_ack_i = 1'b0;
    checks++;
    if ({bus.mem_cyc_o, bus.req_ready_o, bus.rsp_valid_o} !== 3'b010) begin
      errors++; $display("FAIL stray_ack: got cyc/ready/rsp %b expected 010",
                         {bus.mem_cyc_o, bus.req_ready_o, bus.rsp_valid_o});
    end
  endtask

  task automatic test_aligned_write();
    logic [255:0] e = '0;
    set_word(32'h10, rnd256());
    do_op(1'b1, 32'h10, 32, 16, 32'hDEADBEEF, 0, 1'b0);
    e[47:32] = 16'hBEEF;
    checks++;
    if (n_rd !== 0 || n_wr !== 1) begin
      errors++; $display("FAIL aligned_count: rd %0d wr %0d expected 0 1", n_rd, n_wr);
    end
    checks++;
    if (last_wsel !== 32'h0000_0030) begin
      errors++; $display("FAIL aligned_sel: got %h expected 00000030", last_wsel);
    end
    checks++;
    if (last_wdat !== e || last_wadr !== 32'h10) begin
      errors++; $display("FAIL aligned_dat: got %h @%h expected %h @10", last_wdat, last_wadr, e);
    end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL aligned_lat: got %0d expected 2", lat); end
  endtask

  task automatic test_rmw_write();
    logic [255:0] e = {32{8'h55}};
    set_word(32'h20, {32{8'h55}});
    do_op(1'b1, 32'h20, 4, 4, 32'h0000000A, 0, 1'b0);
    e[7:0] = 8'hA5;
    checks++;
    if (n_rd !== 1 || n_wr !== 1 || last_rsel !== 32'hFFFF_FFFF || last_radr !== 32'h20) begin
      errors++; $display("FAIL rmw_read_phase: rd %0d wr %0d rsel %h expected 1 1 ffffffff",
                         n_rd, n_wr, last_rsel);
    end
    checks++;
    if (last_wsel !== 32'h1 || last_wdat !== e) begin
      errors++; $display("FAIL rmw_write: sel %h dat %h expected 1 %h", last_wsel, last_wdat, e);
    end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL rmw_lat: got %0d expected 3", lat); end
  endtask

  task automatic test_read();
    logic [255:0] w = rnd256();
    w[255:232] = 24'hABCDEF;
    set_word(32'h40, w);
    do_op(1'b0, 32'h40, 232, 24, 32'hFFFFFFFF, 0, 1'b0);
    hold_color = 32'h00ABCDEF;
    checks++;
    if (n_rsp !== 1 || rsp_col !== 32'h00ABCDEF) begin
      errors++; $display("FAIL read_rsp: pulses %0d color %h expected 1 00abcdef", n_rsp, rsp_col);
    end
    checks++;
    if (n_rd !== 1 || n_wr !== 0 || lat !== 3) begin
      errors++; $display("FAIL read_bus: rd %0d wr %0d lat %0d expected 1 0 3", n_rd, n_wr, lat);
    end
  endtask

  task automatic test_wide_and_clip();
    logic [255:0] e = '0;
    set_word(32'h30, rnd256());
    do_op(1'b1, 32'h30, 0, 0, 32'h12345678, 0, 1'b0);
    e[31:0] = 32'h12345678;
    checks++;
    if (last_wsel !== 32'hF || last_wdat !== e || n_rd !== 0) begin
      errors++; $display("FAIL bpp0_write: sel %h dat %h rd %0d expected f %h 0",
                         last_wsel, last_wdat, n_rd, e);
    end
    do_op(1'b1, 32'h30, 240, 32, 32'h12345678, 0, 1'b0);
    e = '0;
    e[255:240] = 16'h5678;
    checks++;
    if (last_wsel !== 32'hC000_0000 || last_wdat !== e) begin
      errors++; $display("FAIL clip_write: sel %h dat %h expected c0000000 %h",
                         last_wsel, last_wdat, e);
    end
    checks++;
    if (rsp_col !== 0 || bus.rsp_color_o !== hold_color) begin
      errors++; $display("FAIL rsp_hold: got %h expected %h", bus.rsp_color_o, hold_color);
    end
  endtask

  task automatic test_delayed_ack();
    bit idle_ok = 1;
    logic [255:0] e;
    set_word(32'h50, rnd256());
    e = model_write(ref_mem[32'h50], 3, 5, 32'h15);
    do_op(1'b1, 32'h50, 3, 5, 32'h15, 5, 1'b1);
    ref_mem[32'h50] = e;
    checks++;
    if (!stable_ok) begin errors++; $display("FAIL delay_stable: outputs changed got 0 expected 1"); end
    checks++;
    if (lat !== 13 || n_rd !== 1 || n_wr !== 1) begin
      errors++; $display("FAIL delay_timing: lat %0d rd %0d wr %0d expected 13 1 1", lat, n_rd, n_wr);
    end
    checks++;
    if (bus_mem[32'h50] !== e) begin
      errors++; $display("FAIL delay_mem: got %h expected %h", bus_mem[32'h50], e);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.mem_cyc_o !== 1'b0 || bus.req_ready_o !== 1'b1) idle_ok = 0;
    end
    checks++;
    if (!idle_ok) begin errors++; $display("FAIL delay_second_req: extra op accepted got 0 expected 1"); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      bit we = 1'($urandom_range(0, 1));
      logic [31:0] a = 32'($urandom_range(0, 3));
      int mb = $urandom_range(0, 255);
      int bpp = $urandom_range(0, 63);
      logic [31:0] col = $urandom;
      int dly = $urandom_range(0, 2);
      int exp_rd, exp_lat;
      logic [255:0] e;
      logic [31:0] ec;
      if (n % 6 == 0) mb = 8 * $urandom_range(0, 31);
      if (n % 4 == 0) bpp = 8 * $urandom_range(0, 4);
      if (!bus_mem.exists(a)) set_word(a, rnd256());
      exp_rd = (we && mb % 8 == 0 && bpp % 8 == 0) ? 0 : 1;
      exp_lat = exp_rd * (dly + 1) + (we ? dly + 1 : 1) + 1;
      e = we ? model_write(ref_mem[a], mb, bpp, col) : ref_mem[a];
      ec = model_read(ref_mem[a], mb, bpp);
      do_op(we, a, mb, bpp, col, dly, 1'b0);
      ref_mem[a] = e;
      checks++;
      if (n_rd !== exp_rd || n_wr !== int'(we) || lat !== exp_lat) begin
        errors++; $display("FAIL rand_flow[%0d]: rd %0d wr %0d lat %0d expected %0d %0d %0d",
                           n, n_rd, n_wr, lat, exp_rd, we, exp_lat);
      end
      if (we) begin
        checks++;
        if (last_wsel !== model_sel(mb, bpp) || bus_mem[a] !== e) begin
          errors++; $display("FAIL rand_write[%0d]: mb %0d bpp %0d sel %h mem %h expected %h %h",
                             n, mb, bpp, last_wsel, bus_mem[a], model_sel(mb, bpp), e);
        end
      end else begin
        hold_color = ec;
        checks++;
        if (n_rsp !== 1 || rsp_col !== ec) begin
          errors++; $display("FAIL rand_read[%0d]: mb %0d bpp %0d pulses %0d color %h expected 1 %h",
                             n, mb, bpp, n_rsp, rsp_col, ec);
        end
      end
      checks++;
      if (bus.rsp_color_o !== hold_color) begin
        errors++; $display("FAIL rand_hold[%0d]: got %h expected %h", n, bus.rsp_color_o, hold_color);
      end
    end
  endtask

  task automatic test_reset_during_rd();
    int pulses = 0;
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_adr_i = 32'h1;
    bus.req_mb_i = 8'd8; bus.req_bpp_i = 6'd8;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    checks++;
    if (bus.mem_cyc_o !== 1'b1 || bus.mem_we_o !== 1'b0) begin
      errors++; $display("FAIL rst_rd_setup: cyc %b we %b expected 1 0", bus.mem_cyc_o, bus.mem_we_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_cyc_o !== 1'b0) begin
      errors++; $display("FAIL rst_rd_cyc: got %b expected 0", bus.mem_cyc_o);
    end
    hold_color = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid_o) pulses++;
    end
    checks++;
    if (bus.req_ready_o !== 1'b1 || pulses !== 0 || bus.mem_cyc_o !== 1'b0) begin
      errors++; $display("FAIL rst_rd_after: ready %b pulses %0d cyc %b expected 1 0 0",
                         bus.req_ready_o, pulses, bus.mem_cyc_o);
    end
    checks++;
    if (bus.rsp_color_o !== hold_color) begin
      errors++; $display("FAIL rst_rd_color: got %h expected %h", bus.rsp_color_o, hold_color);
    end
  endtask

  initial begin
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_adr_i = '0; bus.req_mb_i = '0;
    bus.req_bpp_i = '0; bus.req_color_i = '0; bus.mem_dat_i = '0; bus.mem_ack_i = 1'b0;
    hold_color = '0;
    test_reset();
    test_aligned_write();
    test_rmw_write();
    test_read();
    test_wide_and_clip();
    test_delayed_ack();
    test_random();
    test_reset_during_rd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
